// File: rtl/pcihellocore_switch_debouncer_pkg.sv
// Shared constants for the pcihellocore switch debouncer.
// Default sizes plus a helper for prescaler width.
package pcihellocore_switch_debouncer_pkg;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 4;
    localparam int CNT_W            = 4;

    function automatic int presc_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/pcihellocore_debounce_bit.sv
// One switch bit: 2-flop synchronizer, agreement counter, stable flop.
// flip is high in the cycle whose clock edge inverts stable.
module pcihellocore_debounce_bit
    import pcihellocore_switch_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic tick,
    output logic stable,
    output logic flip
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             at_limit;

    assign differ   = sync2 ^ stable;
    assign at_limit = (cnt == CNT_W'(STABLE_TICKS - 1));
    assign flip     = tick & differ & at_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (tick) begin
                // one agreeing sample throws away all progress
                if (!differ) begin
                    cnt <= '0;
                end else if (at_limit) begin
                    cnt    <= '0;
                    stable <= ~stable;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pcihellocore_switch_debouncer.sv
// Debounces WIDTH board switches off a shared sample-tick prescaler.
// Flags any flip on change and records per-bit flips in edge_capture.
module pcihellocore_switch_debouncer
    import pcihellocore_switch_debouncer_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_switches,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] out_port,
    output logic             change,
    output logic [WIDTH-1:0] edge_capture
);

    localparam int            PW   = presc_w(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc;
    logic             tick;
    logic [WIDTH-1:0] flip;

    assign tick = (presc == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pcihellocore_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (raw_switches[i]),
            .tick   (tick),
            .stable (out_port[i]),
            .flip   (flip[i])
        );
    end

    // set beats clear when both land on the same bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            change       <= 1'b0;
            edge_capture <= '0;
        end else begin
            change       <= |flip;
            edge_capture <= (edge_capture & ~edge_clear) | flip;
        end
    end

endmodule

// File: tb/tb_pcihellocore_switch_debouncer.sv
// Randomised and directed bench for the switch debouncer.
// A tick-level behavioural model is compared every cycle.
module tb_pcihellocore_switch_debouncer;

    localparam int W  = 32;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] raw;
    logic [W-1:0] clr;
    logic [W-1:0] out_port;
    logic         change;
    logic [W-1:0] ecap;

    int total;
    int bad;
    int chg_cnt;

    pcihellocore_switch_debouncer #(
        .WIDTH(W),
        .TICK_DIV(TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .raw_switches(raw),
        .edge_clear(clr),
        .out_port(out_port),
        .change(change),
        .edge_capture(ecap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: raw seen two edges late, ticks every TD-th cycle since reset
    logic [W-1:0] m_out;
    logic [W-1:0] m_ecap;
    logic         m_change;
    int           streak [W];
    int           k;
    logic [W-1:0] q [$];

    always @(posedge clk) begin
        logic [W-1:0] s;
        logic [W-1:0] flips;
        if (!reset_n) begin
            m_out = '0;
            m_ecap = '0;
            m_change = 1'b0;
            foreach (streak[i]) streak[i] = 0;
            k = 0;
            q = '{32'h0, 32'h0};
        end else begin
            s = q[0];
            void'(q.pop_front());
            q.push_back(raw);
            flips = '0;
            if (k % TD == TD - 1) begin
                for (int i = 0; i < W; i++) begin
                    if (s[i] != m_out[i]) begin
                        streak[i]++;
                        if (streak[i] == ST) begin
                            flips[i] = 1'b1;
                            streak[i] = 0;
                        end
                    end else begin
                        streak[i] = 0;
                    end
                end
            end
            m_out = m_out ^ flips;
            m_change = |flips;
            m_ecap = (m_ecap & ~clr) | flips;
            k++;
        end
    end

    function automatic logic flip_next(input int b);
        logic [W-1:0] s;
        s = q[0];
        return reset_n && (k % TD == TD - 1) && (s[b] != m_out[b])
               && (streak[b] == ST - 1);
    endfunction

    always @(posedge clk) begin
        #2;
        chk("out_port", out_port, m_out);
        chk("change", {31'b0, change}, {31'b0, m_change});
        chk("edge_capture", ecap, m_ecap);
        if (change) chg_cnt++;
    end

    task automatic wait_bit(input int b, input logic v, output int lat);
        lat = 0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk);
            #2;
            if (out_port[b] == v && lat == 0) lat = i;
        end
    endtask

    task automatic clear_all();
        @(negedge clk);
        clr = '1;
        @(negedge clk);
        clr = '0;
    endtask

    initial begin
        int lat;
        int n;
        total = 0;
        bad = 0;
        chg_cnt = 0;
        reset_n = 1'b0;
        raw = '0;
        clr = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", out_port, 32'h0);
        chk("reset_ecap", ecap, 32'h0);
        reset_n = 1'b1;

        repeat (100) @(negedge clk);
        chk("idle_out", out_port, 32'h0);
        chk("idle_ecap", ecap, 32'h0);
        chk("idle_chg", chg_cnt, 0);

        @(negedge clk);
        raw[0] = 1'b1;
        chg_cnt = 0;
        wait_bit(0, 1'b1, lat);
        chk("b0_lat_min", lat >= 11, 1);
        chk("b0_lat_max", lat <= 14, 1);
        chk("b0_out", out_port, 32'h1);
        chk("b0_pulses", chg_cnt, 1);
        chk("b0_ecap", ecap, 32'h1);

        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c % 5 == 0) raw[5] = ~raw[5];
            chk("b5_bounce", out_port[5], 1'b0);
        end
        raw[5] = 1'b1;
        wait_bit(5, 1'b1, lat);
        chk("b5_hold", lat >= 1 && lat <= 14, 1);

        clear_all();
        chk("ecap_cleared", ecap, 32'h0);
        @(negedge clk);
        raw[0] = 1'b0;
        n = 0;
        while (!flip_next(0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("flip0_timeout", n < 40, 1);
        clr = 32'h1;
        @(negedge clk);
        clr = '0;
        chk("set_wins_out", out_port[0], 1'b0);
        chk("set_wins_ecap", ecap, 32'h1);
        @(negedge clk);
        clr = 32'h1;
        @(negedge clk);
        clr = '0;
        chk("clear_after", ecap, 32'h0);

        raw = '0;
        repeat (30) @(negedge clk);
        clear_all();
        raw = '1;
        chg_cnt = 0;
        repeat (20) @(negedge clk);
        chk("all_out", out_port, 32'hFFFFFFFF);
        chk("all_pulses", chg_cnt, 1);
        chk("all_ecap", ecap, 32'hFFFFFFFF);

        raw = '0;
        repeat (30) @(negedge clk);
        clear_all();
        raw[3] = 1'b1;
        n = 0;
        while (streak[3] != 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b3_two_ticks", n < 40, 1);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_out", out_port, 32'h0);
        end
        reset_n = 1'b1;
        chg_cnt = 0;
        wait_bit(3, 1'b1, lat);
        chk("b3_lat_min", lat >= 11, 1);
        chk("b3_lat_max", lat <= 14, 1);
        chk("b3_pulses", chg_cnt, 1);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0)
                raw = raw ^ ($urandom & $urandom & $urandom);
            clr = $urandom & $urandom & $urandom;
        end
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            raw = $urandom;
            clr = $urandom & $urandom;
            repeat ($urandom_range(5, 20)) @(negedge clk);
        end
        clr = '0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcihellocore_switch_debouncer.md
PCIHELLOCORE_SWITCH_DEBOUNCER -- requirements
Module: pcihellocore_switch_debouncer

Interface
REQ-001 Parameter WIDTH SHALL default to 32 and set the number of switch bits conditioned.
REQ-002 Parameter TICK_DIV SHALL default to 50000 and set the sample-tick period in clk cycles (legal range 1..2^20).
REQ-003 Parameter STABLE_TICKS SHALL default to 4 and set the number of consecutive disagreeing sample ticks before a bit flips (legal range 1..15).
REQ-004 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 raw_switches  input  WIDTH  asynchronous, bouncing board switch levels.
REQ-007 edge_clear  input  WIDTH  write-1-to-clear strobe for edge_capture, one cycle per write.
REQ-008 out_port  output  WIDTH  debounced switch levels; drives in_port of the downstream switcher read port.
REQ-009 change  output  1  one-cycle pulse when any out_port bit flips.
REQ-010 edge_capture  output  WIDTH  sticky per-bit record of out_port flips.

Function
REQ-011 Each raw_switches bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 A prescaler SHALL count 0..TICK_DIV-1, assert tick for one cycle when the count equals TICK_DIV-1, and wrap to 0 on that cycle; TICK_DIV=1 SHALL give tick every cycle.
REQ-013 Per bit, on tick: if the synchronized value differs from out_port, the bit's counter SHALL increment; if it equals out_port, the counter SHALL clear to 0.
REQ-014 When a differing tick arrives with the counter at STABLE_TICKS-1, the out_port bit SHALL invert on that clock edge and its counter SHALL clear to 0.
REQ-015 The counter SHALL hold its value on non-tick cycles; a single agreeing tick SHALL discard all accumulated progress.
REQ-016 Latency from a clean raw level change to out_port SHALL be between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV cycles.
REQ-017 change SHALL assert in the cycle after any out_port bit flips and SHALL be low otherwise; multiple simultaneous bit flips SHALL give one pulse.
REQ-018 edge_capture[i] SHALL set in the cycle after out_port[i] flips (either direction) and SHALL clear in the cycle after edge_clear[i]=1.
REQ-019 Simultaneous flip and edge_clear on the same bit SHALL leave edge_capture set (set wins).
REQ-020 Bits SHALL be fully independent; activity on one bit SHALL not alter another bit's counter.

Reset
REQ-021 During reset_n=0: synchronizer flops, prescaler, all counters, out_port, change and edge_capture SHALL be 0.
REQ-022 Reset asserted mid-debounce SHALL discard progress; after release, a held-high switch SHALL require full STABLE_TICKS ticks to reach out_port.
REQ-023 Reset release SHALL not generate a change pulse or set edge_capture.

Structure
REQ-024 Default TICK_DIV, STABLE_TICKS and WIDTH constants SHALL live in the shared pcihellocore package/header.
REQ-025 Per-bit synchronizer, counter and stable flop SHALL be one sub-module, pcihellocore_debounce_bit, instantiated WIDTH times by generate; the prescaler SHALL be shared in the top level.

Verification (TICK_DIV=4, STABLE_TICKS=3, WIDTH=32)
REQ-026 Reset, hold raw=0 -> out_port=0x00000000, change=0, edge_capture=0 for 100 cycles.
REQ-027 raw bit0 steps 0->1 and holds -> out_port=0x00000001 within 14 cycles, not before 11; change pulses once; edge_capture=0x00000001.
REQ-028 raw bit5 toggles every 5 cycles for 60 cycles then holds 1 -> no flip during toggling; out_port[5]=1 within 14 cycles of the final hold.
REQ-029 edge_capture=0x00000001, edge_clear=0x00000001 in the same cycle bit0 flips back to 0 -> edge_capture stays 0x00000001; next edge_clear clears it to 0.
REQ-030 raw=0xFFFFFFFF step -> all bits flip on the same edge, exactly one change pulse, edge_capture=0xFFFFFFFF.
REQ-031 reset_n pulsed low after 2 ticks of bit3 high -> out_port stays 0 through reset; bit3 sets 11-14 cycles after release.
